// File: rtl/instruction_loader.sv
// Program loader: assembles MSB-first bytes from the UART into 32-bit words and
// writes them to instruction memory, holding the pipeline halted until done.
module instruction_loader #(
  parameter int                 NB_DATA    = 32,
  parameter int                 NB_ADDR    = 8,
  parameter logic [NB_DATA-1:0] END_MARKER = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_rx_valid,
  input  logic [7:0]         i_rx_data,
  output logic               o_we,
  output logic [31:0]        o_inst_addr,
  output logic [NB_DATA-1:0] o_instr_data,
  output logic               o_halt,
  output logic               o_load_done,
  output logic               o_full,
  output logic [NB_ADDR-2:0] o_word_count
);

  localparam int NB_COUNT  = NB_ADDR - 1;
  localparam int MAX_WORDS = 2 ** (NB_ADDR - 2);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, RUN} state_e;

  state_e               state_q, state_d;
  logic [1:0]           byteCnt_q, byteCnt_d;
  logic [NB_DATA-1:0]   asm_q, asm_d;
  logic [NB_COUNT-1:0]  wordCount_q, wordCount_d;
  logic                 we_q, we_d;
  logic [31:0]          addr_q, addr_d;
  logic [NB_DATA-1:0]   data_q, data_d;
  logic                 halt_q, halt_d;
  logic                 done_q, done_d;
  logic                 full_q, full_d;
  logic                 accept;

  always_comb begin
    state_d     = state_q;
    byteCnt_d   = byteCnt_q;
    asm_d       = asm_q;
    wordCount_d = wordCount_q;
    full_d      = full_q;
    addr_d      = addr_q;
    data_d      = data_q;
    accept      = 1'b0;

    case (state_q)
      IDLE, RUN: begin
        if (i_start) begin
          state_d     = RECV;
          byteCnt_d   = 2'd0;
          wordCount_d = '0;
          full_d      = 1'b0;
        end
      end
      RECV: begin
        if (i_start) begin
          byteCnt_d   = 2'd0;
          wordCount_d = '0;
          full_d      = 1'b0;
        end else begin
          accept = i_rx_valid;
        end
      end
      WRITE: begin
        wordCount_d = wordCount_q + 1'b1;
        if (wordCount_q == NB_COUNT'(MAX_WORDS - 1)) begin
          state_d = RUN;
          full_d  = 1'b1;
        end else begin
          state_d = RECV;
          accept  = i_rx_valid;
        end
      end
      default: state_d = IDLE;
    endcase

    // The byte arriving during WRITE is always byte 0, so it never completes a word here.
    if (accept) begin
      asm_d     = {asm_q[NB_DATA-9:0], i_rx_data};
      byteCnt_d = byteCnt_q + 1'b1;
      if (byteCnt_q == 2'd3) begin
        state_d = (asm_d == END_MARKER) ? RUN : WRITE;
      end
    end

    we_d = (state_d == WRITE);
    if (we_d) begin
      addr_d = 32'({wordCount_q[NB_ADDR-3:0], 2'b00});
      data_d = asm_d;
    end
    halt_d = (state_d != RUN);
    done_d = (state_d == RUN) && (state_q != RUN);
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      byteCnt_q   <= 2'd0;
      asm_q       <= '0;
      wordCount_q <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      halt_q      <= 1'b1;
      done_q      <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      byteCnt_q   <= byteCnt_d;
      asm_q       <= asm_d;
      wordCount_q <= wordCount_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      halt_q      <= halt_d;
      done_q      <= done_d;
      full_q      <= full_d;
    end
  end

  assign o_we         = we_q;
  assign o_inst_addr  = addr_q;
  assign o_instr_data = data_q;
  assign o_halt       = halt_q;
  assign o_load_done  = done_q;
  assign o_full       = full_q;
  assign o_word_count = wordCount_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized bench for instruction_loader: a word-level loader model queues the
// expected writes and completions; a negedge monitor pops and compares them.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        o_we;
  logic [31:0] o_inst_addr;
  logic [31:0] o_instr_data;
  logic        o_halt;
  logic        o_load_done;
  logic        o_full;
  logic [6:0]  o_word_count;

  instruction_loader dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_rx_valid   (i_rx_valid),
    .i_rx_data    (i_rx_data),
    .o_we         (o_we),
    .o_inst_addr  (o_inst_addr),
    .o_instr_data (o_instr_data),
    .o_halt       (o_halt),
    .o_load_done  (o_load_done),
    .o_full       (o_full),
    .o_word_count (o_word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          isDone;
    logic [31:0] addr;
    logic [31:0] data;
    int          count;
    bit          full;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Loader model: a load is a list of bytes grouped into words; nothing else.
  bit         mLoading = 0;
  bit         mRun     = 0;
  bit         mFull    = 0;
  int         mCount   = 0;
  logic [7:0] mPartial[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStart();
    mLoading = 1;
    mRun     = 0;
    mFull    = 0;
    mCount   = 0;
    mPartial.delete();
  endtask

  task automatic modelReset();
    mLoading = 0;
    mRun     = 0;
    mFull    = 0;
    mCount   = 0;
    mPartial.delete();
  endtask

  task automatic modelByte(input logic [7:0] b);
    exp_t e;
    logic [31:0] w;
    if (!mLoading) return;
    mPartial.push_back(b);
    if (mPartial.size() == 4) begin
      w = {mPartial[0], mPartial[1], mPartial[2], mPartial[3]};
      mPartial.delete();
      if (w == 32'hFFFF_FFFF) begin
        mLoading = 0;
        mRun     = 1;
        e = '{isDone: 1, addr: 0, data: 0, count: mCount, full: 0};
        expQ.push_back(e);
      end else begin
        e = '{isDone: 0, addr: 32'(mCount * 4), data: w, count: 0, full: 0};
        expQ.push_back(e);
        mCount++;
        if (mCount == 64) begin
          mLoading = 0;
          mRun     = 1;
          mFull    = 1;
          e = '{isDone: 1, addr: 0, data: 0, count: 64, full: 1};
          expQ.push_back(e);
        end
      end
    end
  endtask

  // Monitor: every write or completion the DUT presents must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (o_we) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_we", 32'(o_we), 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("write_kind", 32'(e.isDone), 32'd0);
        checkOutput("write_addr", o_inst_addr, e.addr);
        checkOutput("write_data", o_instr_data, e.data);
      end
    end
    if (o_load_done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 32'(o_load_done), 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("done_kind", 32'(e.isDone), 32'd1);
        checkOutput("done_count", 32'(o_word_count), 32'(e.count));
        checkOutput("done_full", 32'(o_full), 32'(e.full));
        checkOutput("done_halt", 32'(o_halt), 32'd0);
      end
    end
  end

  task automatic idle(input int n);
    i_rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(posedge clk);
    #1;
    modelByte(b);
  endtask

  task automatic sendWord(input logic [31:0] w, input bit gaps);
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(w[8*i +: 8]);
      if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
  endtask

  task automatic startLoad();
    i_rx_valid = 1'b0;
    i_start    = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    modelStart();
  endtask

  task automatic checkIdleState(input string tag);
    idle(3);
    checkOutput({tag, "_halt"}, 32'(o_halt), 32'(!mRun));
    checkOutput({tag, "_count"}, 32'(o_word_count), 32'(mCount));
    checkOutput({tag, "_full"}, 32'(o_full), 32'(mFull));
    checkOutput({tag, "_we"}, 32'(o_we), 32'd0);
    checkOutput({tag, "_queue"}, 32'(expQ.size()), 32'd0);
  endtask

  function automatic logic [31:0] randWord();
    logic [31:0] w;
    w = $urandom;
    if (w == 32'hFFFF_FFFF) w = 32'h1234_5678;
    return w;
  endfunction

  initial begin
    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    modelReset();

    // Reset state, then bytes without a start are ignored
    checkOutput("rst_halt", 32'(o_halt), 32'd1);
    checkOutput("rst_we", 32'(o_we), 32'd0);
    checkOutput("rst_addr", o_inst_addr, 32'd0);
    checkOutput("rst_data", o_instr_data, 32'd0);
    checkOutput("rst_done", 32'(o_load_done), 32'd0);
    checkOutput("rst_full", 32'(o_full), 32'd0);
    checkOutput("rst_count", 32'(o_word_count), 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(8'($urandom));
    checkIdleState("nostart");
    checkOutput("nostart_addr", o_inst_addr, 32'd0);
    checkOutput("nostart_data", o_instr_data, 32'd0);

    // Single instruction then end marker
    startLoad();
    sendWord(32'h2008_0005, 1'b0);
    idle(1);
    sendWord(32'hFFFF_FFFF, 1'b0);
    checkIdleState("single");
    checkOutput("single_data", o_instr_data, 32'h2008_0005);

    // Three words back-to-back with valid held high, then the marker
    startLoad();
    for (int i = 0; i < 3; i++) sendWord(randWord(), 1'b0);
    sendWord(32'hFFFF_FFFF, 1'b0);
    checkIdleState("b2b");

    // Fill memory, then extra bytes must be ignored
    startLoad();
    for (int i = 0; i < 64; i++) sendWord(randWord(), 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(8'($urandom));
    checkIdleState("full");
    checkOutput("full_lastaddr", o_inst_addr, 32'd252);

    // Restart mid-word discards the partial bytes
    startLoad();
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    idle(1);
    startLoad();
    sendWord(randWord(), 1'b1);
    sendWord(32'hFFFF_FFFF, 1'b1);
    checkIdleState("restart");

    // Reset mid-word, then a fresh load
    startLoad();
    sendWord(randWord(), 1'b0);
    applyStimulus(8'hCC);
    applyStimulus(8'hDD);
    i_rx_valid = 1'b0;
    i_rst_n    = 1'b0;
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    modelReset();
    checkOutput("midrst_halt", 32'(o_halt), 32'd1);
    checkOutput("midrst_count", 32'(o_word_count), 32'd0);
    startLoad();
    sendWord(randWord(), 1'b1);
    sendWord(randWord(), 1'b1);
    sendWord(32'hFFFF_FFFF, 1'b1);
    checkIdleState("midrst");

    // Random loads of varying length with random gaps
    for (int n = 0; n < 6; n++) begin
      startLoad();
      for (int i = 0; i < int'($urandom_range(0, 5)); i++) sendWord(randWord(), 1'b1);
      sendWord(32'hFFFF_FFFF, 1'b1);
      checkIdleState("rand");
    end

    idle(4);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Program loader sitting directly upstream of the instruction fetch stage. It takes a byte stream from the UART receiver, assembles 32-bit instructions MSB-first and writes them into instruction memory at consecutive word addresses. While loading it holds the pipeline halted, and it releases the halt when an end marker arrives or memory is full.

## Interface
- NB_DATA, 32, instruction width; the block supports 32 only.
- NB_ADDR, 8, instruction memory byte-address width; word capacity MAX_WORDS = 2^(NB_ADDR-2), i.e. 64.
- END_MARKER, 32'hFFFF_FFFF, word that terminates a load; it is never written to memory.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_start  in  1  one-cycle pulse; starts a new load.
- i_rx_valid  in  1  i_rx_data holds a valid byte this cycle.
- i_rx_data  in  8  received byte.
- o_we  out  1  instruction memory write enable, to fetch i_we.
- o_inst_addr  out  32  byte address of the write, to fetch i_inst_addr; always word aligned.
- o_instr_data  out  32  assembled instruction, to fetch i_instr_data.
- o_halt  out  1  pipeline halt, to fetch i_halt.
- o_load_done  out  1  one-cycle pulse when a load completes.
- o_full  out  1  sticky; the last load ended because memory was full.
- o_word_count  out  NB_ADDR-1  number of words written by the current or last load.

## Operation
- The FSM has four states: IDLE, RECV, WRITE, RUN. Reset enters IDLE.
- All outputs are registered. Reset values: o_we=0, o_inst_addr=0, o_instr_data=0, o_load_done=0, o_full=0, o_word_count=0, o_halt=1.
- IDLE:
  - o_halt=1; i_rx_valid is ignored.
  - i_start -> RECV; clears the byte counter, word index, o_word_count and o_full.
- RECV:
  - o_halt=1.
  - Each i_rx_valid shifts the byte into the assembly register MSB-first: the first byte lands in [31:24], the fourth in [7:0]. The 2-bit byte counter increments.
  - On the 4th byte, if the assembled word equals END_MARKER -> RUN; nothing is written.
  - On the 4th byte, any other word -> WRITE.
- WRITE (exactly one cycle):
  - o_we=1, o_instr_data = assembled word, o_inst_addr = word_index*4, zero-extended to 32 bits.
  - On leaving WRITE, word_index and o_word_count increment.
  - If o_word_count reaches MAX_WORDS -> RUN with o_full=1; otherwise -> RECV.
  - An i_rx_valid byte arriving in this cycle is accepted as byte 0 of the next word.
- RUN:
  - o_halt=0; o_load_done pulses high in the first RUN cycle only.
  - i_rx_valid is ignored.
  - i_start -> RECV with o_halt=1 and counters cleared as in IDLE.
- i_start in RECV restarts the load: the partial word is discarded and counters are cleared. i_start in WRITE is ignored; the write completes normally.
- o_we is 0 in every state except WRITE. o_inst_addr and o_instr_data hold their last values outside WRITE.
- Reset mid-load discards any partial word and returns to IDLE. Memory already written is not cleared.

## Timing
- 4th byte accepted at edge N: o_we=1 during cycle N..N+1; the memory write occurs at edge N+1.
- End marker 4th byte accepted at edge N: o_halt=0 and o_load_done=1 from edge N; o_load_done drops at edge N+1.
- Memory-full case: the RUN transition happens at the edge that ends the last WRITE. o_halt falls at that edge.
- i_start sampled at edge N: o_halt=1 from edge N (if it came from RUN); the first byte is accepted at edge N+1 or later.
- Worst-case byte rate: one byte per cycle, with no loss, including back-to-back words.

## Test plan
- Reset, then a 5-byte partial stream -> o_halt=1, o_we never asserted, all other outputs 0.
- i_start, then bytes 20 08 00 05 and FF FF FF FF:
  - one write: o_inst_addr=0, o_instr_data=32'h2008_0005;
  - then o_halt=0, a single o_load_done pulse, o_word_count=1.
- Three words (12 bytes) driven back-to-back with i_rx_valid held at 1, then the marker -> writes at addresses 0, 4, 8 with correct data, no byte lost, o_word_count=3.
- 64 non-marker words -> last write at address 252, then RUN, o_full=1, o_word_count=64. Extra bytes are ignored and o_we stays 0.
- i_start after 2 bytes of a word -> partial word discarded; the next 4 bytes are written at address 0.
- i_rst_n low mid-word, then a new load -> first write at address 0, and the old partial bytes do not appear in the data.
